cpu_host_seq: RTL and testbench
===============================

Name: cpu_host_seq

Overview:
- Host-side sequencer for the basic-computer core.
- Turns single host commands (RESET, RUN, STOP, STEP, DUMP) into the core's `com_ctl`/`com_addr` control protocol.
- Watches the core's S flag to detect a halt.
- While the core is frozen, streams memory words out over a valid/ready channel.
- Sits between the board-level host interface (UART/debug bridge) and the core.

Parameters:
- RST_CYCLES, 2, number of consecutive cycles `com_ctl` is held at `COM_RST` per RESET command (legal range 1..15).
- AW, 12, memory address width.
- DW, 16, memory word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  command accepted on the cycle where `cmd_valid & cmd_ready`.
- cmd_op  in  3  opcode: 0 NOP, 1 RESET, 2 RUN, 3 STOP, 4 STEP, 5 DUMP; 6/7 are treated as NOP.
- cmd_arg  in  AW  STEP: cycle count; DUMP: start address.
- cmd_len  in  AW  DUMP: word count minus 1.
- cpu_s  in  1  core S (run) flag.
- mem_data  in  DW  core synchronous-RAM read data; valid one cycle after the address is presented.
- com_ctl  out  2  core control, encoded with the `COM_RST`/`COM_RUN`/`COM_STP` defines.
- com_addr  out  AW  memory address used by the core while stopped.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts the dump word.
- dump_addr  out  AW  address of the current dump word.
- dump_data  out  DW  current dump word.
- busy  out  1  high in RESET, STEP and any DUMP state.
- halted  out  1  sticky halt flag.

Behaviour:
- All outputs are registered (Moore).
- Reset values: state STOPPED, `com_ctl`=`COM_STP`, `com_addr`=0, `dump_*`=0, `busy`=0, `halted`=0.
- Async `rst` aborts any operation immediately, including mid-dump or mid-step.
- States: STOPPED, RESETTING, RUNNING, STEPPING, DUMP_RD, DUMP_OUT.
- `cmd_ready` = 1 in STOPPED and RUNNING only; 0 in all other states.
- STOPPED (`com_ctl`=`COM_STP`):
  - RESET → RESETTING, load counter = RST_CYCLES.
  - RUN → RUNNING.
  - STEP with `cmd_arg`=0 → stay in STOPPED (completes immediately).
  - STEP with `cmd_arg`≠0 → STEPPING, counter = `cmd_arg`.
  - DUMP → DUMP_RD, addr = `cmd_arg`, remaining = `cmd_len`.
  - STOP and NOP → no effect.
- RESETTING (`com_ctl`=`COM_RST`):
  - Held for exactly RST_CYCLES cycles, then → STOPPED (no automatic run).
  - Clears `halted` on entry.
- RUNNING (`com_ctl`=`COM_RUN`):
  - STOP → STOPPED. RESET, STEP and DUMP are accepted with the same transitions as from STOPPED. RUN and NOP → no effect.
  - If `cpu_s`=0 and no command is accepted that cycle → STOPPED with `halted`=1.
  - An accepted command has priority over halt detection.
- STEPPING (`com_ctl`=`COM_RUN`):
  - Exactly N cycles with `com_ctl`=`COM_RUN`, N = `cmd_arg` (1..4095), then → STOPPED.
  - If `cpu_s`=0 is sampled, terminate early → STOPPED with `halted`=1.
- DUMP_RD (`com_ctl`=`COM_STP`):
  - Drive `com_addr`=addr for one cycle, then → DUMP_OUT.
  - On entering DUMP_OUT, capture `mem_data` into `dump_data`, set `dump_addr`=addr and `dump_valid`=1.
- DUMP_OUT: hold `dump_valid`, `dump_addr` and `dump_data` stable until `dump_ready`. On handshake:
  - If remaining=0 → STOPPED, `dump_valid`=0.
  - Otherwise → DUMP_RD with addr+1 (modulo 2^AW, so 0xFFF wraps to 0x000), remaining−1, `dump_valid`=0.
- Dump throughput: at most one word per 2 cycles. A length of 0x000 dumps 1 word; 0xFFF dumps 4096 words.
- The core's memory write enable is gated during STP, so a dump never writes memory.
- `halted` stays set until a RESET command.
- Issuing RUN while `halted` is legal: the core ignores it because S=0, so `halted` re-triggers the next cycle.

Decomposition:
- Shared defines header (the existing core defines file):
  - `COM_*` encodings.
  - New `HOSTOP_NOP/RESET/RUN/STOP/STEP/DUMP` opcode constants.
  - State encodings.
- One sub-module, `cnt_down_ld` (loadable AW-bit down-counter with zero flag), instanced twice:
  - reset/step cycle count;
  - dump words remaining.
- Address increment is inline.

Test Plan:
- Power-on: assert `rst` asynchronously mid-cycle → `com_ctl`=`COM_STP`, `com_addr`=0, `dump_valid`=0, `halted`=0, `cmd_ready`=1.
- RESET cmd → `COM_RST` for exactly 2 cycles, then `COM_STP`; `cmd_ready`=0 during, 1 after; a preset `halted` is cleared.
- STEP `cmd_arg`=5 with `cpu_s`=1 → exactly 5 consecutive `COM_RUN` cycles, then STOPPED; STEP `cmd_arg`=0 → `com_ctl` never leaves `COM_STP`.
- RUN, then drive `cpu_s`=0 → next cycle `com_ctl`=`COM_STP`, `halted`=1.
- Same run, but with STOP accepted on the same cycle `cpu_s`=0 is sampled → STOPPED with `halted`=0.
- DUMP `cmd_arg`=0xFFE, `cmd_len`=2, RAM model preloaded → words at 0xFFE, 0xFFF, 0x000 in order with matching data. Hold `dump_ready`=0 for 3 cycles on word 2 → its outputs stay stable. Return to STOPPED after the third handshake.
- Assert `rst` during DUMP_OUT → `dump_valid` drops immediately, state STOPPED, no further `com_addr` changes.

Source files
------------

// File: rtl/cpu_host_seq_pkg.sv
// Shared definitions for the host-side sequencer of the basic-computer core.
// Contents: core control encodings (COM_*), host opcodes (HOSTOP_*),
// sequencer state encoding, and a helper that maps a state to the com_ctl value.
package cpu_host_seq_pkg;

    // Core control protocol encodings
    localparam logic [1:0] COM_STP = 2'b00;
    localparam logic [1:0] COM_RUN = 2'b01;
    localparam logic [1:0] COM_RST = 2'b10;

    // Host command opcodes; 6 and 7 decode as NOP
    localparam logic [2:0] HOSTOP_NOP   = 3'd0;
    localparam logic [2:0] HOSTOP_RESET = 3'd1;
    localparam logic [2:0] HOSTOP_RUN   = 3'd2;
    localparam logic [2:0] HOSTOP_STOP  = 3'd3;
    localparam logic [2:0] HOSTOP_STEP  = 3'd4;
    localparam logic [2:0] HOSTOP_DUMP  = 3'd5;

    typedef enum logic [2:0] {
        ST_STOPPED   = 3'd0,
        ST_RESETTING = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_STEPPING  = 3'd3,
        ST_DUMP_RD   = 3'd4,
        ST_DUMP_OUT  = 3'd5
    } seq_state_t;

    function automatic logic [1:0] state_com_ctl(input seq_state_t s);
        logic [1:0] v;
        v = COM_STP;
        case (s)
            ST_RESETTING: v = COM_RST;
            ST_RUNNING:   v = COM_RUN;
            ST_STEPPING:  v = COM_RUN;
            default:      v = COM_STP;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cpu_host_seq_cnt_down_ld.sv
// Loadable down-counter with zero flag.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_load        load i_load_val (has priority over decrement)
//   i_load_val    value to load
//   i_dec         decrement by one; saturates at zero
//   o_zero        count is zero
module cnt_down_ld #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/cpu_host_seq.sv
// Host-side sequencer for the basic-computer core. Converts single host
// commands into the core's com_ctl/com_addr protocol, detects halts via the
// core S flag, and streams memory words over a valid/ready channel while the
// core is stopped.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       host command handshake
//   cmd_op, cmd_arg, cmd_len  opcode, STEP count / DUMP start, DUMP length-1
//   cpu_s                     core run flag (0 = core halted)
//   mem_data                  core RAM read data for com_addr
//   com_ctl, com_addr         core control and stopped-mode address
//   dump_valid/dump_ready     dump word handshake
//   dump_addr, dump_data      current dump word and its address
//   busy                      RESETTING, STEPPING or dumping
//   halted                    sticky halt flag, cleared by RESET
//
// state      | meaning
// STOPPED    | core frozen (COM_STP), accepting commands
// RESETTING  | COM_RST held for RST_CYCLES cycles
// RUNNING    | free run (COM_RUN), accepting commands, watching cpu_s
// STEPPING   | COM_RUN for a fixed number of cycles
// DUMP_RD    | com_addr presented to the RAM for one cycle
// DUMP_OUT   | dump word offered until dump_ready
module cpu_host_seq
    import cpu_host_seq_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int AW         = 12,
    parameter int DW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_arg,
    input  logic [AW-1:0] cmd_len,
    input  logic          cpu_s,
    input  logic [DW-1:0] mem_data,
    output logic [1:0]    com_ctl,
    output logic [AW-1:0] com_addr,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          busy,
    output logic          halted
);

    seq_state_t    r_state;
    seq_state_t    w_state_nxt;
    logic          r_cmd_ready;
    logic [1:0]    r_com_ctl;
    logic [AW-1:0] r_com_addr;
    logic          r_dump_valid;
    logic [AW-1:0] r_dump_addr;
    logic [DW-1:0] r_dump_data;
    logic          r_busy;
    logic          r_halted;

    logic          w_accept;
    logic          w_halted_nxt;
    logic [AW-1:0] w_com_addr_nxt;
    logic          w_dump_valid_nxt;
    logic [AW-1:0] w_dump_addr_nxt;
    logic [DW-1:0] w_dump_data_nxt;
    logic          w_tmr_load;
    logic [AW-1:0] w_tmr_val;
    logic          w_tmr_dec;
    logic          w_tmr_zero;
    logic          w_rem_load;
    logic          w_rem_dec;
    logic          w_rem_zero;

    assign w_accept = cmd_valid & r_cmd_ready;

    // Cycle counter for RESETTING/STEPPING. Loaded with N-1 so the last
    // cycle of the window is the one where the counter reads zero.
    cnt_down_ld #(.W(AW)) u_tmr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // Words remaining after the current one (cmd_len is already length-1).
    cnt_down_ld #(.W(AW)) u_rem (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_rem_load),
        .i_load_val (cmd_len),
        .i_dec      (w_rem_dec),
        .o_zero     (w_rem_zero)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_halted_nxt     = r_halted;
        w_com_addr_nxt   = r_com_addr;
        w_dump_valid_nxt = r_dump_valid;
        w_dump_addr_nxt  = r_dump_addr;
        w_dump_data_nxt  = r_dump_data;
        w_tmr_load       = 1'b0;
        w_tmr_val        = '0;
        w_tmr_dec        = 1'b0;
        w_rem_load       = 1'b0;
        w_rem_dec        = 1'b0;

        case (r_state)
            ST_STOPPED, ST_RUNNING: begin
                // An accepted command (even a no-effect one) wins over halt
                // detection in the same cycle.
                if (w_accept) begin
                    case (cmd_op)
                        HOSTOP_RESET: begin
                            w_state_nxt  = ST_RESETTING;
                            w_tmr_load   = 1'b1;
                            w_tmr_val    = AW'(RST_CYCLES - 1);
                            w_halted_nxt = 1'b0;
                        end
                        HOSTOP_RUN:  w_state_nxt = ST_RUNNING;
                        HOSTOP_STOP: w_state_nxt = ST_STOPPED;
                        HOSTOP_STEP: begin
                            if (cmd_arg != '0) begin
                                w_state_nxt = ST_STEPPING;
                                w_tmr_load  = 1'b1;
                                w_tmr_val   = cmd_arg - 1'b1;
                            end else begin
                                w_state_nxt = ST_STOPPED;
                            end
                        end
                        HOSTOP_DUMP: begin
                            w_state_nxt    = ST_DUMP_RD;
                            w_com_addr_nxt = cmd_arg;
                            w_rem_load     = 1'b1;
                        end
                        default: ;
                    endcase
                end else if ((r_state == ST_RUNNING) && !cpu_s) begin
                    w_state_nxt  = ST_STOPPED;
                    w_halted_nxt = 1'b1;
                end
            end
            ST_RESETTING: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_STOPPED;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_STEPPING: begin
                if (!cpu_s) begin
                    w_state_nxt  = ST_STOPPED;
                    w_halted_nxt = 1'b1;
                end else if (w_tmr_zero) begin
                    w_state_nxt = ST_STOPPED;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_DUMP_RD: begin
                // com_addr has been stable for a full cycle, so mem_data now
                // belongs to it.
                w_state_nxt      = ST_DUMP_OUT;
                w_dump_valid_nxt = 1'b1;
                w_dump_addr_nxt  = r_com_addr;
                w_dump_data_nxt  = mem_data;
            end
            ST_DUMP_OUT: begin
                if (dump_ready) begin
                    w_dump_valid_nxt = 1'b0;
                    if (w_rem_zero) begin
                        w_state_nxt = ST_STOPPED;
                    end else begin
                        w_state_nxt    = ST_DUMP_RD;
                        w_com_addr_nxt = r_com_addr + 1'b1;
                        w_rem_dec      = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_STOPPED;
        endcase
    end

    // State-decoded outputs are registered from the next state so they line
    // up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_STOPPED;
            r_cmd_ready  <= 1'b1;
            r_com_ctl    <= COM_STP;
            r_com_addr   <= '0;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd_ready  <= (w_state_nxt == ST_STOPPED) || (w_state_nxt == ST_RUNNING);
            r_com_ctl    <= state_com_ctl(w_state_nxt);
            r_com_addr   <= w_com_addr_nxt;
            r_dump_valid <= w_dump_valid_nxt;
            r_dump_addr  <= w_dump_addr_nxt;
            r_dump_data  <= w_dump_data_nxt;
            r_busy       <= (w_state_nxt == ST_RESETTING) || (w_state_nxt == ST_STEPPING) ||
                            (w_state_nxt == ST_DUMP_RD)   || (w_state_nxt == ST_DUMP_OUT);
            r_halted     <= w_halted_nxt;
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign com_ctl    = r_com_ctl;
    assign com_addr   = r_com_addr;
    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;
    assign busy       = r_busy;
    assign halted     = r_halted;

endmodule

// File: tb/tb_cpu_host_seq.sv
// Directed self-checking bench for cpu_host_seq.
module tb_cpu_host_seq;
    import cpu_host_seq_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [AW-1:0] cmd_arg = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          cpu_s = 1'b1;
    logic [DW-1:0] mem_data;
    logic [1:0]    com_ctl;
    logic [AW-1:0] com_addr;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          busy;
    logic          halted;

    logic [DW-1:0] mem [0:4095];

    int n_cmp = 0;
    int n_err = 0;

    // Core RAM read path: data for com_addr is settled by the next edge.
    assign mem_data = mem[com_addr];

    always #5 clk = ~clk;

    cpu_host_seq #(.RST_CYCLES(2), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .cmd_len    (cmd_len),
        .cpu_s      (cpu_s),
        .mem_data   (mem_data),
        .com_ctl    (com_ctl),
        .com_addr   (com_addr),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .busy       (busy),
        .halted     (halted)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int chg;

        for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'hA5A5;

        // Power-on: asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        check("por_com_ctl",   32'(com_ctl),    32'(COM_STP));
        check("por_com_addr",  32'(com_addr),   32'h0);
        check("por_dump_vld",  32'(dump_valid), 32'h0);
        check("por_halted",    32'(halted),     32'h0);
        check("por_cmd_ready", 32'(cmd_ready),  32'h1);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        check("idle_busy", 32'(busy), 32'h0);

        // RUN, then core halts
        cmd_valid = 1'b1; cmd_op = HOSTOP_RUN;
        cyc();
        cmd_valid = 1'b0;
        check("run_com_ctl",   32'(com_ctl),   32'(COM_RUN));
        check("run_cmd_ready", 32'(cmd_ready), 32'h1);
        cyc();
        check("run_still", 32'(com_ctl), 32'(COM_RUN));
        cpu_s = 1'b0;
        cyc();
        cpu_s = 1'b1;
        check("halt_com_ctl", 32'(com_ctl), 32'(COM_STP));
        check("halt_flag",    32'(halted),  32'h1);

        // RESET: two COM_RST cycles, clears halted
        cmd_valid = 1'b1; cmd_op = HOSTOP_RESET;
        cyc();
        cmd_valid = 1'b0;
        check("rst_c1_com_ctl", 32'(com_ctl),   32'(COM_RST));
        check("rst_c1_ready",   32'(cmd_ready), 32'h0);
        check("rst_c1_busy",    32'(busy),      32'h1);
        check("rst_halt_clr",   32'(halted),    32'h0);
        cyc();
        check("rst_c2_com_ctl", 32'(com_ctl), 32'(COM_RST));
        cyc();
        check("rst_end_com_ctl", 32'(com_ctl),   32'(COM_STP));
        check("rst_end_ready",   32'(cmd_ready), 32'h1);
        check("rst_end_busy",    32'(busy),      32'h0);

        // STEP 5
        cmd_valid = 1'b1; cmd_op = HOSTOP_STEP; cmd_arg = 12'd5;
        cyc();
        cmd_valid = 1'b0;
        check("step5_ready", 32'(cmd_ready), 32'h0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (com_ctl != COM_RUN) break;
            n++;
            cyc();
        end
        check("step5_run_cycles", 32'(n), 32'd5);
        check("step5_end_ctl",    32'(com_ctl), 32'(COM_STP));
        check("step5_end_busy",   32'(busy),    32'h0);

        // STEP 0: never leaves COM_STP
        cmd_valid = 1'b1; cmd_op = HOSTOP_STEP; cmd_arg = 12'd0;
        cyc();
        cmd_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (com_ctl !== COM_STP || busy !== 1'b0) n++;
            cyc();
        end
        check("step0_non_stp", 32'(n), 32'd0);
        check("step0_ready",   32'(cmd_ready), 32'h1);

        // RUN, then STOP accepted in the same cycle cpu_s drops
        cmd_valid = 1'b1; cmd_op = HOSTOP_RUN;
        cyc();
        check("run2_com_ctl", 32'(com_ctl), 32'(COM_RUN));
        cmd_op = HOSTOP_STOP; cpu_s = 1'b0;
        cyc();
        cmd_valid = 1'b0; cpu_s = 1'b1;
        check("stop_pri_com_ctl", 32'(com_ctl), 32'(COM_STP));
        check("stop_pri_halted",  32'(halted),  32'h0);
        cyc();
        check("stop_pri_halted2", 32'(halted), 32'h0);

        // DUMP 0xFFE, 3 words, wrapping
        dump_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = HOSTOP_DUMP; cmd_arg = 12'hFFE; cmd_len = 12'd2;
        cyc();
        cmd_valid = 1'b0;
        check("d_rd0_addr",  32'(com_addr),   32'hFFE);
        check("d_rd0_vld",   32'(dump_valid), 32'h0);
        check("d_rd0_busy",  32'(busy),       32'h1);
        check("d_rd0_ctl",   32'(com_ctl),    32'(COM_STP));
        cyc();
        check("d_w0", {3'b0, dump_valid, dump_addr, dump_data}, {3'b0, 1'b1, 12'hFFE, 16'hAA5B});
        dump_ready = 1'b1;
        cyc();
        dump_ready = 1'b0;
        check("d_rd1_addr", 32'(com_addr),   32'hFFF);
        check("d_rd1_vld",  32'(dump_valid), 32'h0);
        cyc();
        check("d_w1", {3'b0, dump_valid, dump_addr, dump_data}, {3'b0, 1'b1, 12'hFFF, 16'hAA5A});
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("d_w1_hold", {3'b0, dump_valid, dump_addr, dump_data}, {3'b0, 1'b1, 12'hFFF, 16'hAA5A});
        end
        dump_ready = 1'b1;
        cyc();
        check("d_rd2_addr", 32'(com_addr),   32'h000);
        check("d_rd2_vld",  32'(dump_valid), 32'h0);
        cyc();
        check("d_w2", {3'b0, dump_valid, dump_addr, dump_data}, {3'b0, 1'b1, 12'h000, 16'hA5A5});
        cyc();
        dump_ready = 1'b0;
        check("d_end_vld",   32'(dump_valid), 32'h0);
        check("d_end_busy",  32'(busy),       32'h0);
        check("d_end_ready", 32'(cmd_ready),  32'h1);

        // Async reset during DUMP_OUT
        cmd_valid = 1'b1; cmd_op = HOSTOP_DUMP; cmd_arg = 12'h010; cmd_len = 12'd5;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        check("ra_pre_vld", 32'(dump_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("ra_vld",   32'(dump_valid), 32'h0);
        check("ra_addr",  32'(com_addr),   32'h0);
        check("ra_ctl",   32'(com_ctl),    32'(COM_STP));
        check("ra_busy",  32'(busy),       32'h0);
        check("ra_ready", 32'(cmd_ready),  32'h1);
        cyc();
        cyc();
        rst = 1'b0;
        chg = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (com_addr !== 12'h000 || dump_valid !== 1'b0) chg++;
        end
        check("ra_quiet", 32'(chg), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
